// File: rtl/adder_sum_monitor.sv
// Observer for a registered WIDTH-bit adder: predicts A+B, checks the sum one clock later, counts errors.
// Define SUM_MON_TOGGLE_EN to build the sum toggle-activity counter; otherwise o_toggle_cnt is tied to 0.
module adder_sum_monitor #(
  parameter int WIDTH  = 4,
  parameter int CNT_W  = 16,
  parameter int WINDOW = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH:0]   i_sum,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_sample_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic [CNT_W-1:0] o_toggle_cnt,
  output logic [WIDTH:0]   o_first_err
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] L_WINDOW  = CNT_W'(WINDOW);
  localparam logic [CNT_W-1:0] L_CNT_MAX = '1;

  state_t           r_state, w_state_nxt;
  logic [WIDTH:0]   r_exp;
  logic             r_pend;
  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [WIDTH:0]   r_first_err;
  logic             w_issue;
  logic             w_cmp;
  logic             w_mismatch;

  assign w_issue    = (r_state == S_RUN) && i_valid && (r_issued < L_WINDOW);
  assign w_cmp      = (r_state == S_RUN) && r_pend;
  assign w_mismatch = w_cmp && (i_sum != r_exp);

  always_comb begin
    w_state_nxt = r_state;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) w_state_nxt = S_ARM;
      S_ARM: begin
        o_busy      = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        o_busy = 1'b1;
        if ((r_issued == L_WINDOW) && !r_pend) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_exp        <= '0;
      r_pend       <= 1'b0;
      r_issued     <= '0;
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_first_err  <= '0;
    end else if (r_state == S_ARM) begin
      r_pend       <= 1'b0;
      r_issued     <= '0;
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_first_err  <= '0;
    end else if (r_state == S_RUN) begin
      // issue and compare are independent so back-to-back samples keep r_pend high
      if (w_issue) begin
        r_exp    <= {1'b0, i_a} + {1'b0, i_b};
        r_pend   <= 1'b1;
        r_issued <= r_issued + CNT_W'(1);
      end else begin
        r_pend <= 1'b0;
      end
      if (w_cmp) r_sample_cnt <= r_sample_cnt + CNT_W'(1);
      if (w_mismatch) begin
        if (r_err_cnt != L_CNT_MAX) r_err_cnt <= r_err_cnt + CNT_W'(1);
        if (r_err_cnt == '0)        r_first_err <= i_sum;
      end
    end
  end

  assign o_sample_cnt = r_sample_cnt;
  assign o_err_cnt    = r_err_cnt;
  assign o_first_err  = r_first_err;

`ifdef SUM_MON_TOGGLE_EN
  localparam int L_FL_W = $clog2(WIDTH + 2);
  localparam int L_TS_W = CNT_W + 1;

  logic [WIDTH:0]    r_prev_sum;
  logic [CNT_W-1:0]  r_toggle_cnt;
  logic [WIDTH:0]    w_diff;
  logic [L_FL_W-1:0] w_flips;
  logic [CNT_W:0]    w_tog_sum;

  assign w_diff = i_sum ^ r_prev_sum;

  always_comb begin
    w_flips = '0;
    for (int i = 0; i <= WIDTH; i++) w_flips = w_flips + L_FL_W'(w_diff[i]);
  end

  assign w_tog_sum = {1'b0, r_toggle_cnt} + L_TS_W'(w_flips);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prev_sum   <= '0;
      r_toggle_cnt <= '0;
    end else if (r_state == S_ARM) begin
      r_prev_sum   <= i_sum;
      r_toggle_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_prev_sum   <= i_sum;
      r_toggle_cnt <= w_tog_sum[CNT_W] ? L_CNT_MAX : w_tog_sum[CNT_W-1:0];
    end
  end

  assign o_toggle_cnt = r_toggle_cnt;
`else
  assign o_toggle_cnt = '0;
`endif

endmodule

// File: tb/tb_adder_sum_monitor.sv
// Bench for adder_sum_monitor: a registered adder model feeds two monitors (WINDOW=3 and WINDOW=2);
// each window's expectations come from a sample-list model of the monitor's rules.
module tb_adder_sum_monitor;
  localparam int NJ = 48;

  logic        clk = 1'b0;
  logic        rst;
  logic        start3, start2, valid, ovr;
  logic [3:0]  a, b;
  logic [4:0]  ovr_val;
  logic [4:0]  sum_q = '0;
  logic        busy3, done3, busy2, done2;
  logic [15:0] sc3, ec3, tc3, sc2, ec2, tc2;
  logic [4:0]  fe3, fe2;

  int n_cmp = 0;
  int n_bad = 0;

  logic        sel2 = 1'b0;
  logic        m_busy, m_done;
  logic [15:0] m_sc, m_ec, m_tc;
  logic [4:0]  m_fe;
  assign m_busy = sel2 ? busy2 : busy3;
  assign m_done = sel2 ? done2 : done3;
  assign m_sc   = sel2 ? sc2 : sc3;
  assign m_ec   = sel2 ? ec2 : ec3;
  assign m_tc   = sel2 ? tc2 : tc3;
  assign m_fe   = sel2 ? fe2 : fe3;

  // per-RUN-cycle stimulus pattern and what was seen in each cycle
  logic       pv[NJ], pst[NJ], pov[NJ];
  logic [3:0] pa[NJ], pb[NJ];
  logic [4:0] pov_val[NJ];
  logic [4:0] s_rec[NJ];
  logic       d_rec[NJ], b_rec[NJ];
  logic [4:0] s_arm;
  logic       arm_busy;

  int         e_sc, e_ec, e_tc, e_done_at;
  logic [4:0] e_fe;
  int         a_done_at, a_done_n, a_busy_n;

  always #5 clk = ~clk;

  // registered adder under observation; ovr injects a wrong result
  always @(posedge clk) sum_q <= ovr ? ovr_val : ({1'b0, a} + {1'b0, b});

  adder_sum_monitor #(.WIDTH(4), .CNT_W(16), .WINDOW(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(start3), .i_valid(valid), .i_a(a), .i_b(b), .i_sum(sum_q),
    .o_busy(busy3), .o_done(done3), .o_sample_cnt(sc3), .o_err_cnt(ec3), .o_toggle_cnt(tc3),
    .o_first_err(fe3));

  adder_sum_monitor #(.WIDTH(4), .CNT_W(16), .WINDOW(2)) u_dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .i_valid(valid), .i_a(a), .i_b(b), .i_sum(sum_q),
    .o_busy(busy2), .o_done(done2), .o_sample_cnt(sc2), .o_err_cnt(ec2), .o_toggle_cnt(tc2),
    .o_first_err(fe2));

  task automatic clear_pattern();
    for (int j = 0; j < NJ; j++) begin
      pv[j]      = 1'b0;
      pst[j]     = 1'b0;
      pov[j]     = 1'b0;
      pa[j]      = 4'($urandom_range(0, 15));
      pb[j]      = 4'($urandom_range(0, 15));
      pov_val[j] = 5'($urandom_range(0, 31));
    end
  endtask

  task automatic random_pattern();
    clear_pattern();
    for (int j = 0; j < 36; j++) begin
      pv[j]  = ($urandom_range(0, 99) < 60);
      pov[j] = ($urandom_range(0, 99) < 15);
    end
    for (int j = 30; j < 36; j++) pv[j] = 1'b1;
    pst[0] = 1'($urandom_range(0, 1));
    pst[1] = 1'($urandom_range(0, 1));
  endtask

  task automatic run_window(input bit use2);
    sel2 = use2;
    @(negedge clk);
    if (use2) start2 = 1'b1; else start3 = 1'b1;
    @(negedge clk);
    start2   = 1'b0;
    start3   = 1'b0;
    s_arm    = sum_q;
    arm_busy = m_busy;
    valid    = 1'($urandom_range(0, 1));
    a        = 4'($urandom_range(0, 15));
    b        = 4'($urandom_range(0, 15));
    ovr      = 1'b0;
    for (int j = 0; j < NJ; j++) begin
      @(negedge clk);
      s_rec[j] = sum_q;
      b_rec[j] = m_busy;
      d_rec[j] = m_done;
      valid    = pv[j];
      a        = pa[j];
      b        = pb[j];
      ovr      = pov[j];
      ovr_val  = pov_val[j];
      if (use2) start2 = pst[j]; else start3 = pst[j];
    end
    @(negedge clk);
    valid  = 1'b0;
    ovr    = 1'b0;
    start2 = 1'b0;
    start3 = 1'b0;
    a_done_at = -1;
    a_done_n  = 0;
    a_busy_n  = 0;
    for (int j = 0; j < NJ; j++) begin
      if (d_rec[j]) begin
        if (a_done_at < 0) a_done_at = j;
        a_done_n++;
      end
      if (b_rec[j]) a_busy_n++;
    end
  endtask

  // accepted samples are the first win valids in RUN; each one's result appears on sum the next cycle
  task automatic model_window(input int win);
    int         acc;
    int         k;
    logic [4:0] exp_s;
    logic [4:0] prev;
    acc  = 0;
    k    = -1;
    e_ec = 0;
    e_fe = '0;
    e_tc = 0;
    for (int j = 0; j < NJ - 1; j++) begin
      if (pv[j] && acc < win) begin
        acc++;
        k     = j;
        exp_s = {1'b0, pa[j]} + {1'b0, pb[j]};
        if (s_rec[j+1] != exp_s) begin
          if (e_ec == 0) e_fe = s_rec[j+1];
          e_ec++;
        end
      end
    end
    e_sc      = acc;
    e_done_at = k + 3;
    prev      = s_arm;
    for (int j = 0; j <= k + 2; j++) begin
      e_tc += $countones(s_rec[j] ^ prev);
      prev  = s_rec[j];
    end
`ifndef SUM_MON_TOGGLE_EN
    e_tc = 0;
`endif
  endtask

  task automatic test_reset();
    logic [109:0] obs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      obs = {busy3, done3, sc3, ec3, tc3, fe3, busy2, done2, sc2, ec2, tc2, fe2};
      n_cmp++;
      if (obs !== '0) begin
        n_bad++;
        $display("FAIL reset_idle cycle %0d: outputs=%h required 0", i, obs);
      end
    end
  endtask

  task automatic test_ideal();
    clear_pattern();
    pv[0] = 1; pa[0] = 4'd2; pb[0] = 4'd3;
    pv[1] = 1; pa[1] = 4'd4; pb[1] = 4'd5;
    pv[2] = 1; pa[2] = 4'd8; pb[2] = 4'd6;
    run_window(1'b0);
    model_window(3);
    n_cmp++; if (arm_busy !== 1'b1) begin n_bad++; $display("FAIL ideal_arm_busy: got %b need 1", arm_busy); end
    n_cmp++; if (m_sc !== 16'd3) begin n_bad++; $display("FAIL ideal_sample_cnt: got %0d need 3", m_sc); end
    n_cmp++; if (m_ec !== 16'd0) begin n_bad++; $display("FAIL ideal_err_cnt: got %0d need 0", m_ec); end
    n_cmp++; if (m_fe !== 5'd0) begin n_bad++; $display("FAIL ideal_first_err: got %0d need 0", m_fe); end
    n_cmp++; if (a_done_at != 5) begin n_bad++; $display("FAIL ideal_done_latency: done at RUN cycle %0d need 5", a_done_at); end
    n_cmp++; if (a_done_n != 1) begin n_bad++; $display("FAIL ideal_done_pulses: got %0d need 1", a_done_n); end
    n_cmp++; if (a_busy_n != 5) begin n_bad++; $display("FAIL ideal_busy_cycles: got %0d need 5", a_busy_n); end
    n_cmp++; if (m_tc !== 16'(e_tc)) begin n_bad++; $display("FAIL ideal_toggle_cnt: got %0d need %0d", m_tc, e_tc); end
  endtask

  task automatic test_error();
    clear_pattern();
    pv[0] = 1; pa[0] = 4'd2; pb[0] = 4'd3;
    pv[1] = 1; pa[1] = 4'd4; pb[1] = 4'd5;
    pv[2] = 1; pa[2] = 4'd8; pb[2] = 4'd6; pov[2] = 1; pov_val[2] = 5'd15;
    run_window(1'b0);
    n_cmp++; if (m_ec !== 16'd1) begin n_bad++; $display("FAIL error_err_cnt: got %0d need 1", m_ec); end
    n_cmp++; if (m_fe !== 5'd15) begin n_bad++; $display("FAIL error_first_err: got %0d need 15", m_fe); end
    n_cmp++; if (m_sc !== 16'd3) begin n_bad++; $display("FAIL error_sample_cnt: got %0d need 3", m_sc); end
  endtask

  task automatic test_toggle();
    clear_pattern();
    pv[0] = 1; pa[0] = 4'd15; pb[0] = 4'd15;
    pv[1] = 1; pa[1] = 4'd0;  pb[1] = 4'd0;
    pv[2] = 1; pa[2] = 4'd1;  pb[2] = 4'd2;
    run_window(1'b0);
    model_window(3);
    n_cmp++; if (m_tc !== 16'(e_tc)) begin n_bad++; $display("FAIL toggle_cnt: got %0d need %0d", m_tc, e_tc); end
    n_cmp++; if (m_ec !== 16'd0) begin n_bad++; $display("FAIL toggle_err_cnt: got %0d need 0", m_ec); end
  endtask

  task automatic test_drop();
    clear_pattern();
    for (int j = 0; j < 5; j++) pv[j] = 1'b1;
    pst[2] = 1'b1;
    run_window(1'b1);
    n_cmp++; if (m_sc !== 16'd2) begin n_bad++; $display("FAIL drop_sample_cnt: got %0d need 2", m_sc); end
    n_cmp++; if (a_done_at != 4) begin n_bad++; $display("FAIL drop_done_latency: done at RUN cycle %0d need 4", a_done_at); end
    n_cmp++; if (a_done_n != 1) begin n_bad++; $display("FAIL drop_done_pulses: got %0d need 1", a_done_n); end
    n_cmp++; if (a_busy_n != 4) begin n_bad++; $display("FAIL drop_busy_cycles: got %0d need 4", a_busy_n); end
  endtask

  task automatic test_random();
    bit use2;
    for (int w = 0; w < 6; w++) begin
      use2 = (w % 2) == 1;
      random_pattern();
      run_window(use2);
      model_window(use2 ? 2 : 3);
      n_cmp++; if (m_sc !== 16'(e_sc)) begin n_bad++; $display("FAIL rand%0d_sample_cnt: got %0d need %0d", w, m_sc, e_sc); end
      n_cmp++; if (m_ec !== 16'(e_ec)) begin n_bad++; $display("FAIL rand%0d_err_cnt: got %0d need %0d", w, m_ec, e_ec); end
      n_cmp++; if (m_fe !== e_fe) begin n_bad++; $display("FAIL rand%0d_first_err: got %0d need %0d", w, m_fe, e_fe); end
      n_cmp++; if (m_tc !== 16'(e_tc)) begin n_bad++; $display("FAIL rand%0d_toggle_cnt: got %0d need %0d", w, m_tc, e_tc); end
      n_cmp++; if (a_done_at != e_done_at) begin n_bad++; $display("FAIL rand%0d_done_latency: got %0d need %0d", w, a_done_at, e_done_at); end
      n_cmp++; if (a_done_n != 1) begin n_bad++; $display("FAIL rand%0d_done_pulses: got %0d need 1", w, a_done_n); end
    end
  endtask

  task automatic test_reset_mid();
    logic [54:0] obs;
    int          n_done;
    sel2 = 1'b0;
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0; valid = 1'b0;
    @(negedge clk); valid = 1'b1; a = 4'd3; b = 4'd4; ovr = 1'b0;
    @(negedge clk); valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (sc3 !== 16'd1 || busy3 !== 1'b1) begin
      n_bad++;
      $display("FAIL midrst_before: sample_cnt=%0d busy=%b need 1/1", sc3, busy3);
    end
    #2 rst = 1'b1;
    #1 obs = {busy3, done3, sc3, ec3, tc3, fe3};
    n_cmp++; if (obs !== '0) begin n_bad++; $display("FAIL midrst_async_clear: outputs=%h required 0", obs); end
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    n_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done3 === 1'b1 || busy3 === 1'b1) n_done++;
    end
    n_cmp++; if (n_done != 0) begin n_bad++; $display("FAIL midrst_no_done: %0d cycles with busy/done need 0", n_done); end
    random_pattern();
    run_window(1'b0);
    model_window(3);
    n_cmp++; if (m_sc !== 16'(e_sc)) begin n_bad++; $display("FAIL midrst_clean_sample_cnt: got %0d need %0d", m_sc, e_sc); end
    n_cmp++; if (m_ec !== 16'(e_ec)) begin n_bad++; $display("FAIL midrst_clean_err_cnt: got %0d need %0d", m_ec, e_ec); end
    n_cmp++; if (a_done_n != 1) begin n_bad++; $display("FAIL midrst_clean_done_pulses: got %0d need 1", a_done_n); end
  endtask

  initial begin
    rst     = 1'b1;
    start3  = 1'b0;
    start2  = 1'b0;
    valid   = 1'b0;
    ovr     = 1'b0;
    ovr_val = '0;
    a       = '0;
    b       = '0;
    test_reset();
    test_ideal();
    test_error();
    test_toggle();
    test_drop();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
